// File: rtl/nand_share_pkg.sv
// nand_share_pkg: shared state type and sizing helpers for nand_share_arbiter
package nand_share_pkg;
    typedef enum logic [1:0] {IDLE, EVAL, RESP} arb_state_t;
    localparam int NUM_REQ_MAX = 8;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/NAND_GATE.sv
// NAND_GATE: two-input NAND cell from the base logic library
module NAND_GATE (
    input  logic in0,
    input  logic in1,
    output logic out
);
    assign out = ~(in0 & in1);
endmodule

// File: rtl/nand_share_arbiter.sv
// nand_share_arbiter: round-robin sharing of one NAND_GATE among NUM_REQ requesters
// Optional saturating per-requester grant counters: define NAND_SHARE_ARB_STATS_EN
module nand_share_arbiter
    import nand_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_in0,
    input  logic [NUM_REQ-1:0]       req_in1,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic                     rsp_out,
    output logic                     busy,
    output logic [NUM_REQ*CNT_W-1:0] grant_cnt
);
    localparam int IW = idx_w(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > NUM_REQ_MAX) begin : g_bad_num_req
        $error("nand_share_arbiter: NUM_REQ out of range");
    end

    arb_state_t         state_q, state_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d, g_q, g_d, gi;
    logic [IW:0]        j;
    logic               op0_q, op0_d, op1_q, op1_d, res_q, res_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic               busy_q, busy_d;
    logic               found, hs, nand_out;

    NAND_GATE u_nand (
        .in0(op0_q),
        .in1(op1_q),
        .out(nand_out)
    );

    // Scan upward from rr_ptr with wrap-around for the first pending requester
    always_comb begin
        found = 1'b0;
        gi = '0;
        j = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = {1'b0, rr_ptr_q} + (IW+1)'(k);
            if (j >= (IW+1)'(NUM_REQ)) j = j - (IW+1)'(NUM_REQ);
            if (!found && req_valid[j[IW-1:0]]) begin
                found = 1'b1;
                gi = j[IW-1:0];
            end
        end
    end

    assign hs = (state_q == IDLE) && found && !rst;

    // Grant decode, next state and datapath updates
    always_comb begin
        req_ready = '0;
        if (hs) req_ready[gi] = 1'b1;
        state_d = hs ? EVAL : (state_q == EVAL) ? RESP : IDLE;
        rr_ptr_d = hs ? ((gi == IW'(NUM_REQ - 1)) ? '0 : gi + 1'b1) : rr_ptr_q;
        g_d = hs ? gi : g_q;
        op0_d = hs ? req_in0[gi] : op0_q;
        op1_d = hs ? req_in1[gi] : op1_q;
        res_d = (state_q == EVAL) ? nand_out : 1'b0;
        rsp_valid_d = '0;
        if (state_q == EVAL) rsp_valid_d[g_q] = 1'b1;
        busy_d = (state_d != IDLE);
    end

    // State and datapath registers; reset aborts any transaction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            g_q         <= '0;
            op0_q       <= 1'b0;
            op1_q       <= 1'b0;
            res_q       <= 1'b0;
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            g_q         <= g_d;
            op0_q       <= op0_d;
            op1_q       <= op1_d;
            res_q       <= res_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_out   = res_q;
    assign busy      = busy_q;

`ifdef NAND_SHARE_ARB_STATS_EN
    logic [NUM_REQ-1:0][CNT_W-1:0] cnt_q, cnt_d;

    // Count handshakes per requester, holding at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (hs && cnt_q[gi] != '1) cnt_d[gi] = cnt_q[gi] + 1'b1;
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end

    assign grant_cnt = cnt_q;
`else
    assign grant_cnt = '0;
`endif
endmodule

// File: tb/tb_nand_share_arbiter.sv
// tb_nand_share_arbiter: scoreboard bench for nand_share_arbiter (NUM_REQ=4, CNT_W=2)
module tb_nand_share_arbiter;
    localparam int N  = 4;
    localparam int CW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_in0, req_in1;
    logic [N-1:0]   req_ready, rsp_valid;
    logic           rsp_out, busy;
    logic [N*CW-1:0] grant_cnt;

    typedef struct {
        logic [N-1:0] v;
        logic         o;
    } rsp_t;

    rsp_t sb[$];
    int   cnt_m[N];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    nand_share_arbiter #(.NUM_REQ(N), .CNT_W(CW)) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_in0(req_in0),
        .req_in1(req_in1),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_out(rsp_out),
        .busy(busy),
        .grant_cnt(grant_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [N*CW-1:0] exp_cnt();
        logic [N*CW-1:0] r;
        r = '0;
`ifdef NAND_SHARE_ARB_STATS_EN
        for (int i = 0; i < N; i++) r[i*CW +: CW] = CW'(cnt_m[i]);
`endif
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        step();
        rst = 1'b0;
        for (int i = 0; i < N; i++) cnt_m[i] = 0;
    endtask

    task automatic run_txn(input logic [N-1:0] v, input logic [N-1:0] i0, input logic [N-1:0] i1,
                           input int exp_g, input bit drop, output int t);
        int n;
        rsp_t e;
        logic [N-1:0] g1;
        g1 = N'(1) << exp_g;
        req_valid = v;
        req_in0 = i0;
        req_in1 = i1;
        #1;
        n = 0;
        while (req_ready == '0 && n < 40) begin
            step();
            #1;
            n++;
        end
        t = cyc;
        checks++;
        if (req_ready !== g1) begin
            errors++;
            $display("FAIL grant: req_ready=%b expected %b (waited %0d cycles)", req_ready, g1, n);
        end
        if (req_ready == '0) return;
        e.v = g1;
        e.o = ~(i0[exp_g] & i1[exp_g]);
        sb.push_back(e);
        if (cnt_m[exp_g] < (1 << CW) - 1) cnt_m[exp_g]++;
        step();
        if (drop) req_valid[exp_g] = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1 || rsp_valid !== '0 || req_ready !== '0 || grant_cnt !== exp_cnt()) begin
            errors++;
            $display("FAIL eval: busy=%b rsp_valid=%b req_ready=%b grant_cnt=%h expected 1 0000 0000 %h",
                     busy, rsp_valid, req_ready, grant_cnt, exp_cnt());
        end
        step();
        e = sb.pop_front();
        checks++;
        if (rsp_valid !== e.v || rsp_out !== e.o || busy !== 1'b1) begin
            errors++;
            $display("FAIL rsp: rsp_valid=%b rsp_out=%b busy=%b expected %b %b 1",
                     rsp_valid, rsp_out, busy, e.v, e.o);
        end
        step();
        checks++;
        if (busy !== 1'b0 || rsp_valid !== '0) begin
            errors++;
            $display("FAIL idle: busy=%b rsp_valid=%b expected 0 0000", busy, rsp_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '1;
        req_in0 = '1;
        req_in1 = '1;
        for (int i = 0; i < N; i++) cnt_m[i] = 0;
        repeat (3) begin
            step();
            checks++;
            if (req_ready !== '0 || rsp_valid !== '0 || rsp_out !== 1'b0 || busy !== 1'b0 || grant_cnt !== '0) begin
                errors++;
                $display("FAIL reset: req_ready=%b rsp_valid=%b rsp_out=%b busy=%b grant_cnt=%h expected all 0",
                         req_ready, rsp_valid, rsp_out, busy, grant_cnt);
            end
        end
        rst = 1'b0;
        req_valid = '0;
        step();
    endtask

    task automatic test_single();
        int t;
        run_txn(4'b0001, 4'b0001, 4'b0001, 0, 1'b1, t);
    endtask

    task automatic test_truth_table();
        int t;
        logic [1:0] p;
        for (int k = 0; k < 4; k++) begin
            p = 2'(k);
            run_txn(4'b0100, {1'b0, p[0], 2'b00}, {1'b0, p[1], 2'b00}, 2, 1'b1, t);
        end
    endtask

    task automatic test_round_robin();
        int t, tp;
        do_reset();
        tp = 0;
        for (int k = 0; k < 5; k++) begin
            run_txn(4'b1111, N'($urandom), N'($urandom), k % N, 1'b0, t);
            if (k > 0) begin
                checks++;
                if (t - tp !== 3) begin
                    errors++;
                    $display("FAIL rr_gap: grant %0d spacing=%0d expected 3", k, t - tp);
                end
            end
            tp = t;
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_pointer_skip();
        int t;
        run_txn(4'b0010, 4'b0010, 4'b0000, 1, 1'b1, t);
        run_txn(4'b1001, 4'b1000, 4'b1000, 3, 1'b1, t);
        run_txn(4'b0001, 4'b0001, 4'b0000, 0, 1'b1, t);
    endtask

    task automatic test_reset_eval();
        int n, t;
        req_valid = 4'b0010;
        req_in0 = 4'b0010;
        req_in1 = 4'b0010;
        #1;
        n = 0;
        while (req_ready == '0 && n < 40) begin
            step();
            #1;
            n++;
        end
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL abort_grant: req_ready=%b expected 0010", req_ready);
        end
        step();
        rst = 1'b1;
        req_valid = '0;
        step();
        checks++;
        if (req_ready !== '0 || rsp_valid !== '0 || rsp_out !== 1'b0 || busy !== 1'b0 || grant_cnt !== '0) begin
            errors++;
            $display("FAIL abort_rst: req_ready=%b rsp_valid=%b rsp_out=%b busy=%b grant_cnt=%h expected all 0",
                     req_ready, rsp_valid, rsp_out, busy, grant_cnt);
        end
        rst = 1'b0;
        for (int i = 0; i < N; i++) cnt_m[i] = 0;
        repeat (2) begin
            step();
            checks++;
            if (rsp_valid !== '0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_pulse: rsp_valid=%b busy=%b expected 0000 0", rsp_valid, busy);
            end
        end
        run_txn(4'b1011, 4'b0001, 4'b0000, 0, 1'b1, t);
    endtask

    task automatic test_stats();
        int t;
        logic [N*CW-1:0] fin;
        do_reset();
        for (int k = 0; k < 5; k++) run_txn(4'b0001, 4'b0001, N'(k & 1), 0, 1'b1, t);
`ifdef NAND_SHARE_ARB_STATS_EN
        fin = 8'h03;
`else
        fin = '0;
`endif
        checks++;
        if (grant_cnt !== fin) begin
            errors++;
            $display("FAIL stats_final: grant_cnt=%h expected %h", grant_cnt, fin);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_in0 = '0;
        req_in1 = '0;
        test_reset();
        test_single();
        test_truth_table();
        test_round_robin();
        test_pointer_skip();
        test_reset_eval();
        test_stats();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard: %0d responses outstanding, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
